ifu_fetch_unit: RTL and testbench
=================================

// Module: ifu_fetch_unit
// PURPOSE
//  Instruction fetch unit: producer side of the instruction stream consumed by IDU_top.
//  Owns the fetch PC, issues in-order word reads to instruction memory, buffers returned words
//  in a small FIFO and presents them to the IDU with a valid/ready handshake.
//  Accepts control-flow redirects from the CU, flushing buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  soc_clk         in   1   system clock, all state on rising edge
//  IFU_reset       in   1   asynchronous, active-high reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned read address
//  imem_rsp_valid  in   1   read response valid (in order, no backpressure)
//  imem_rsp_data   in   32  returned instruction word
//  imem_rsp_err    in   1   bus error on this response
//  instruction     out  32  instruction word to IDU (FIFO head)
//  instr_pc        out  32  PC of instruction
//  instr_valid     out  1   instruction/instr_pc valid
//  instr_ready     in   1   IDU accepts head this cycle
//  redirect_valid  in   1   CU redirect (branch/jump/trap) this cycle
//  redirect_pc     in   32  redirect target
//  fetch_fault     out  1   sticky: bus error or misaligned redirect
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0,
//   imem_req_addr=RESET_PC, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0,
//   fetch_fault=0; state=IDLE. Reset mid-operation discards everything; later responses ignored.
//  FSM: IDLE -> FETCH on first clock after reset release (no request issued in IDLE).
//   FETCH -> FAULT on accepted (non-dropped) response with imem_rsp_err, or redirect with
//   redirect_pc[1:0]!=0. FAULT -> FETCH on aligned redirect (clears fetch_fault).
//  Credits: imem_req_valid=1 in FETCH iff outstanding + fifo_count < FIFO_DEPTH.
//   imem_req_addr=fetch_pc; on valid&ready: fetch_pc+=4 (32-bit wrap, FFFF_FFFC->0000_0000),
//   outstanding+=1. Response: outstanding-=1. Request stays stable until ready.
//  Response with drop_cnt>0: discarded, drop_cnt-=1 (err ignored). Otherwise data+pc pushed
//   to FIFO; visible on instruction/instr_valid the next cycle (1-cycle rsp->IDU latency).
//   Each FIFO entry carries its own PC (request address), not fetch_pc.
//  IDU side: head popped on instr_valid&instr_ready; instruction/instr_pc held stable while
//   instr_valid&!instr_ready. When empty, instr_valid=0 and instruction holds last value.
//   Simultaneous push and pop on full FIFO is legal (credit scheme prevents overflow).
//  Redirect (highest priority): FIFO flushed same edge, instr_valid=0 next cycle,
//   fetch_pc<=redirect_pc, drop_cnt<=outstanding (+1 if request handshake same cycle,
//   -1 if response same cycle); new request earliest next cycle. Redirect while drop_cnt>0
//   accumulates correctly; no request to redirect_pc until credits allow.
//  FAULT: no new requests; entries already in FIFO still delivered; error response itself
//   not pushed; remaining outstanding responses dropped.
//  Invariant: outstanding+fifo_count <= FIFO_DEPTH; drop_cnt <= outstanding.
// TESTING
//  1 Reset release, mem ready=1, 1-cycle rsp, instr_ready=1 -> addrs 0,4,8.. in order;
//    instruction/instr_pc pairs match memory image; no gaps after warm-up.
//  2 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, head held stable,
//    no drops; release -> stream resumes at next sequential PC.
//  3 Redirect to 32'h0000_0100 with 2 outstanding -> both responses dropped, first
//    delivered instr_pc=0x100, no pre-redirect word reaches IDU.
//  4 imem_rsp_err on addr 0x8 -> words 0x0,0x4 delivered, fetch_fault=1, no requests;
//    redirect 0x40 -> fault clears, fetch resumes at 0x40.
//  5 Redirect to 32'h0000_0102 -> fetch_fault=1, FAULT, no request issued.
//  6 Assert IFU_reset mid-stream with outstanding=2 -> outputs at reset values immediately;
//    post-release first request addr=RESET_PC, stale responses never delivered.

Source files
------------

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: issues in-order word reads, buffers returned words in a small FIFO
// and hands them to the decoder; redirects flush buffered and in-flight fetches.
module ifu_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        soc_clk,
    input  logic        IFU_reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [31:0]     hold_instr_reg, hold_pc_reg;
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [31:0]     fifo_pc   [FIFO_DEPTH];

    logic            credit_ok, req_fire, rsp_seen, rsp_live, err_hit;
    logic            push, pop, redirect_misaligned;
    logic [31:0]     rsp_pc;

    // A response arriving with nothing outstanding is a leftover from before reset.
    assign rsp_seen            = imem_rsp_valid && (outstanding_reg != '0);
    assign rsp_live            = rsp_seen && (drop_cnt_reg == '0);
    assign err_hit             = rsp_live && imem_rsp_err && (state_reg == S_FETCH);
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

    assign credit_ok      = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = (state_reg == S_FETCH) && credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Live requests since the last redirect are contiguous, so the oldest one sits
    // exactly 'outstanding' words behind the fetch PC.
    assign rsp_pc = fetch_pc_reg - (32'(outstanding_reg) << 2);

    assign instr_valid = count_reg != '0;
    assign instruction = instr_valid ? fifo_data[rd_ptr_reg] : hold_instr_reg;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_reg]   : hold_pc_reg;
    assign fetch_fault = state_reg == S_FAULT;

    assign push = rsp_live && !imem_rsp_err && !redirect_valid && (state_reg == S_FETCH);
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (err_hit) state_next = S_FAULT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
        if (redirect_valid) begin
            state_next = redirect_misaligned ? S_FAULT : S_FETCH;
        end
    end

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_seen);
        drop_cnt_next    = drop_cnt_reg;
        count_next       = count_reg + CW'(push) - CW'(pop);
        rd_ptr_next      = rd_ptr_reg + PW'(pop);
        wr_ptr_next      = wr_ptr_reg + PW'(push);

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end

        // Everything still in flight after this edge belongs to a dead stream.
        if (redirect_valid || err_hit) begin
            drop_cnt_next = outstanding_next;
        end else if (rsp_seen && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
        end

        if (redirect_valid) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
    end

    always_ff @(posedge soc_clk or posedge IFU_reset) begin
        if (IFU_reset) begin
            state_reg       <= S_IDLE;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            hold_instr_reg  <= NOP;
            hold_pc_reg     <= RESET_PC;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            if (instr_valid) begin
                hold_instr_reg <= fifo_data[rd_ptr_reg];
                hold_pc_reg    <= fifo_pc[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge soc_clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= imem_rsp_data;
            fifo_pc[wr_ptr_reg]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Bench for ifu_fetch_unit: in-order memory model with random latency, a stream-level
// scoreboard (expected PC sequence, epochs for killed fetches), directed phases and random traffic.
module tb_ifu_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        soc_clk;
    logic        IFU_reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    ifu_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .soc_clk        (soc_clk),
        .IFU_reset      (IFU_reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        bit          err;
    } req_t;

    typedef struct {
        string       name;
        int          cycles;
        bit          idu_rdy;
        int          lat;
        bit          redir;
        logic [31:0] redir_pc;
        bit          err_en;
        logic [31:0] err_addr;
        bit          exp_fault;
        int          exp_reqv;
        int          exp_ndeliv;
        bit          chk_first;
        logic [31:0] exp_first;
    } phase_t;

    req_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          last_due = 0;
    bit          idle = 1'b1;
    bit          model_fault = 1'b0;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] exp_deliv = RESET_PC;
    logic [31:0] last_pc = RESET_PC;
    logic [31:0] last_word = NOP;

    bit          rdy_rand = 1'b0;
    bit          idu_rand = 1'b0;
    bit          idu_rdy = 1'b1;
    int          lat_max = 1;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h1;
    int          err_rate = 0;
    bit          redir_go = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    bit          stale_go = 1'b0;
    int          ndeliv = 0;
    logic [31:0] first_deliv = 32'hDEAD_DEAD;
    bit          first_req_seen = 1'b0;
    logic [31:0] first_req = 32'hDEAD_DEAD;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        buffered    = 0;
        idle        = 1'b1;
        model_fault = 1'b0;
        exp_req     = RESET_PC;
        exp_deliv   = RESET_PC;
        last_pc     = RESET_PC;
        last_word   = NOP;
        last_due    = 0;
        epoch++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        chk({tag, "_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_instruction"}, instruction, NOP);
        chk({tag, "_instr_pc"}, instr_pc, RESET_PC);
        chk({tag, "_fault"}, fetch_fault, 1'b0);
    endtask

    // One clock cycle: drive inputs just after the falling edge, sample 1 time unit later,
    // then advance the stream model by what the coming rising edge will do.
    task automatic step();
        bit   do_rsp, fire, redir, push, pop, err_live, rv_exp;
        req_t h, n;
        int   d;
        imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        instr_ready    = idu_rand ? ($urandom_range(0, 2) != 0) : idu_rdy;
        do_rsp         = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = do_rsp || stale_go;
        imem_rsp_data  = do_rsp ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        imem_rsp_err   = do_rsp ? mq[0].err : 1'b0;
        redir          = redir_go;
        redirect_valid = redir;
        redirect_pc    = redir ? redir_tgt : $urandom;
        redir_go       = 1'b0;
        stale_go       = 1'b0;
        #1;
        rv_exp = !idle && !model_fault && ((mq.size() + buffered) < DEPTH);
        chk("req_valid", imem_req_valid, rv_exp);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
        chk("instr_valid", instr_valid, buffered != 0);
        if (buffered != 0) begin
            chk("instr_pc", instr_pc, exp_deliv);
            chk("instruction", instruction, mem_word(exp_deliv));
        end else begin
            chk("held_pc", instr_pc, last_pc);
            chk("held_instruction", instruction, last_word);
        end
        chk("fetch_fault", fetch_fault, model_fault);

        fire     = imem_req_valid && imem_req_ready;
        push     = 1'b0;
        err_live = 1'b0;
        if (do_rsp) begin
            h = mq.pop_front();
            if (!redir && h.epoch == epoch) begin
                if (h.err) err_live = 1'b1;
                else       push = 1'b1;
            end
        end
        if (fire) begin
            if (!first_req_seen) begin
                first_req_seen = 1'b1;
                first_req      = imem_req_addr;
            end
            d = cyc + int'($urandom_range(1, lat_max));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            n.addr  = imem_req_addr;
            n.epoch = epoch;
            n.due   = d;
            n.err   = err_en && ((imem_req_addr == err_addr) ||
                                 (err_rate > 0 && $urandom_range(1, err_rate) == 1));
            mq.push_back(n);
            exp_req = exp_req + 32'd4;
        end
        pop = (buffered != 0) && instr_ready;
        if (buffered != 0) begin
            last_pc   = exp_deliv;
            last_word = mem_word(exp_deliv);
        end
        if (pop) begin
            if (ndeliv == 0) first_deliv = exp_deliv;
            ndeliv++;
            exp_deliv = exp_deliv + 32'd4;
        end
        buffered = buffered + int'(push) - int'(pop);
        if (err_live) begin
            model_fault = 1'b1;
            epoch++;
        end
        if (redir) begin
            epoch++;
            buffered    = 0;
            exp_req     = redir_tgt;
            exp_deliv   = redir_tgt;
            model_fault = redir_tgt[1:0] != 2'b00;
        end
        idle = 1'b0;
        @(negedge soc_clk);
        cyc++;
    endtask

    phase_t phases[9];

    initial begin
        int n;
        phases[0] = '{"stream_from_reset", 12, 1, 1, 0, 32'h0, 0, 32'h1, 0, -1, -1, 1, 32'h0};
        phases[1] = '{"idu_stall",         10, 0, 1, 0, 32'h0, 0, 32'h1, 0,  0,  0, 0, 32'h0};
        phases[2] = '{"idu_release",        6, 1, 3, 0, 32'h0, 0, 32'h1, 0, -1, -1, 0, 32'h0};
        phases[3] = '{"redirect_0x100",    10, 1, 1, 1, 32'h100, 0, 32'h1, 0, -1, -1, 1, 32'h100};
        phases[4] = '{"err_at_0x8",        12, 1, 1, 1, 32'h0, 1, 32'h8, 1,  0,  2, 1, 32'h0};
        phases[5] = '{"redirect_0x40",      8, 1, 1, 1, 32'h40, 0, 32'h1, 0, -1, -1, 1, 32'h40};
        phases[6] = '{"misaligned_0x102",   5, 1, 1, 1, 32'h102, 0, 32'h1, 1,  0,  0, 0, 32'h0};
        phases[7] = '{"redirect_0x200",     8, 1, 2, 1, 32'h200, 0, 32'h1, 0, -1, -1, 1, 32'h200};
        phases[8] = '{"pc_wrap",           10, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h1, 0, -1, -1, 1, 32'hFFFF_FFF8};

        IFU_reset      = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge soc_clk);
        @(negedge soc_clk);
        check_reset_outputs("reset");
        IFU_reset = 1'b0;
        model_reset();

        foreach (phases[pi]) begin
            idu_rdy     = phases[pi].idu_rdy;
            lat_max     = phases[pi].lat;
            err_en      = phases[pi].err_en;
            err_addr    = phases[pi].err_addr;
            ndeliv      = 0;
            first_deliv = 32'hDEAD_DEAD;
            for (int c = 0; c < phases[pi].cycles; c++) begin
                if (c == 0 && phases[pi].redir) begin
                    redir_go  = 1'b1;
                    redir_tgt = phases[pi].redir_pc;
                    step();
                    ndeliv      = 0;
                    first_deliv = 32'hDEAD_DEAD;
                end else begin
                    step();
                end
            end
            chk({phases[pi].name, "_fault"}, fetch_fault, phases[pi].exp_fault);
            if (phases[pi].exp_reqv >= 0)
                chk({phases[pi].name, "_req_valid"}, imem_req_valid, phases[pi].exp_reqv[0]);
            if (phases[pi].exp_ndeliv >= 0)
                chk({phases[pi].name, "_delivered"}, ndeliv, phases[pi].exp_ndeliv);
            if (phases[pi].chk_first)
                chk({phases[pi].name, "_first_pc"}, first_deliv, phases[pi].exp_first);
            $display("PHASE %s cycles=%0d delivered=%0d fault=%0b", phases[pi].name,
                     phases[pi].cycles, ndeliv, fetch_fault);
        end

        // Reset in the middle of a stream with two reads outstanding.
        err_en    = 1'b0;
        lat_max   = 3;
        idu_rdy   = 1'b1;
        redir_go  = 1'b1;
        redir_tgt = 32'h300;
        step();
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("rst_outstanding", mq.size(), 2);
        IFU_reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge soc_clk);
        #1;
        check_reset_outputs("midreset_held");
        @(negedge soc_clk);
        IFU_reset      = 1'b0;
        stale_go       = 1'b1;
        first_req_seen = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("first_req_seen", first_req_seen, 1'b1);
        chk("first_req_after_reset", first_req, RESET_PC);
        $display("PHASE reset_midstream first_req=%h", first_req);

        // Random traffic with backpressure, variable latency, redirects and bus errors.
        rdy_rand = 1'b1;
        idu_rand = 1'b1;
        lat_max  = 3;
        err_en   = 1'b1;
        err_addr = 32'h1;
        err_rate = 25;
        ndeliv   = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                redir_go  = 1'b1;
                redir_tgt = 32'($urandom_range(0, 1023)) << 2;
                if ($urandom_range(0, 5) == 0) redir_tgt[1:0] = 2'b10;
            end
            step();
        end
        $display("PHASE random cycles=3000 delivered=%0d", ndeliv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
